stream_reporter: RTL and testbench

Debug report source that pairs with the two-channel report harvester. On a harvest request it snapshots a probe vector and a free-running cycle timestamp. It then serializes the header, timestamp and probe words onto a ready/valid stream, holding `reporting` high from capture until the last word is accepted. One instance sits behind each harvester input channel.

---
 rtl/stream_report_pkg.sv | 16 +
 rtl/report_word_shifter.sv | 40 ++++
 rtl/stream_reporter.sv | 130 +++++++++++++
 tb/tb_stream_reporter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_report_pkg.sv
// Shared definitions for the stream report source.
// State encoding, default word width and sizing helper.
package stream_report_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] TS     = 2'd2;
  localparam logic [1:0] PROBE  = 2'd3;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/report_word_shifter.sv
// Report word shifter: parallel load of the whole report, then
// shift right one word per accept; the low word is the output.
// Ports: clk, arst, load_i, shift_i, data_i[NW*WIDTH], word_o[WIDTH].
module report_word_shifter
  import stream_report_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NW    = 6
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [NW*WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]      word_o
);

  logic [NW*WIDTH-1:0] sr_q;
  logic [NW*WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q >> WIDTH;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign word_o = sr_q[WIDTH-1:0];

endmodule

// File: rtl/stream_reporter.sv
// Debug report source: snapshots probe + timestamp on request and
// streams header, timestamp and probe words over ready/valid.
// Ports: clk, arst, probe, start_harvest, reporting,
//        dout_ready, dout_valid, dout[WIDTH].
module stream_reporter
  import stream_report_pkg::*;
#(
  parameter int         WIDTH   = DEFAULT_WIDTH,
  parameter int         PROBE_W = 32,
  parameter int         TS_W    = 16,
  parameter logic [7:0] ID      = 8'h00
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [PROBE_W-1:0] probe,
  input  logic               start_harvest,
  output logic               reporting,
  input  logic               dout_ready,
  output logic               dout_valid,
  output logic [WIDTH-1:0]   dout
);

  localparam int NT = ceil_div(TS_W, WIDTH);
  localparam int NP = ceil_div(PROBE_W, WIDTH);
  localparam int NW = 1 + NT + NP;
  localparam int CW = $clog2(NW + 1);

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   idx_d;
  logic [TS_W-1:0] ts_q;
  logic            load;
  logic            accept;

  logic [NP*WIDTH-1:0] probe_pad;
  logic [NT*WIDTH-1:0] ts_pad;
  logic [WIDTH-1:0]    id_w;

  // Free-running timestamp, never stalls.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign accept = dout_valid && dout_ready;

  // idx_q counts words already accepted in this report.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_harvest) begin
          state_d = HEADER;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      HEADER: begin
        if (accept) begin
          state_d = TS;
          idx_d   = idx_q + CW'(1);
        end
      end
      TS: begin
        if (accept) begin
          idx_d = idx_q + CW'(1);
          if (idx_q == CW'(NT)) begin
            state_d = PROBE;
          end
        end
      end
      PROBE: begin
        if (accept) begin
          idx_d = idx_q + CW'(1);
          if (idx_q == CW'(NW - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    reporting  = (state_q != IDLE);
    dout_valid = (state_q != IDLE);
  end

  always_comb begin
    probe_pad              = '0;
    probe_pad[PROBE_W-1:0] = probe;
    ts_pad                 = '0;
    ts_pad[TS_W-1:0]       = ts_q;
    id_w                   = '0;
    id_w[7:0]              = ID;
  end

  report_word_shifter #(
    .WIDTH (WIDTH),
    .NW    (NW)
  ) u_shift (
    .clk     (clk),
    .arst    (arst),
    .load_i  (load),
    .shift_i (accept),
    .data_i  ({probe_pad, ts_pad, id_w}),
    .word_o  (dout)
  );

endmodule

// File: tb/tb_stream_reporter.sv
// Self-checking bench for stream_reporter.
// Directed vector table plus multi-cycle corner sequences.
module tb_stream_reporter;

  logic        clk;
  logic        arst;
  logic [19:0] probe;
  logic        start_harvest;
  logic        reporting;
  logic        dout_ready;
  logic        dout_valid;
  logic [7:0]  dout;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] ts_m;
  logic [15:0] tcap;

  stream_reporter #(
    .WIDTH   (8),
    .PROBE_W (20),
    .TS_W    (16),
    .ID      (8'hA5)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .probe         (probe),
    .start_harvest (start_harvest),
    .reporting     (reporting),
    .dout_ready    (dout_ready),
    .dout_valid    (dout_valid),
    .dout          (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or posedge arst) begin
    if (arst) ts_m <= '0;
    else      ts_m <= ts_m + 16'd1;
  end

  typedef struct {
    logic        start;
    logic        rdy;
    logic [19:0] p;
    logic        exp_rep;
    logic        chk_dout;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain one report already captured; checks every word in order.
  // pat 0: ready always, pat 1: ready 1,0,0,1 repeating.
  task automatic drain(input logic [19:0] p, input logic [15:0] t,
                       input int pat, input bit chg,
                       input bit retrig, input bit hold);
    logic [7:0] w[6];
    int idx;
    int k;
    w[0] = 8'hA5;
    w[1] = t[7:0];
    w[2] = t[15:8];
    w[3] = p[7:0];
    w[4] = p[15:8];
    w[5] = {4'h0, p[19:16]};
    idx = 0;
    k = 0;
    while (idx < 6 && k < 64) begin
      chk("valid", {31'd0, dout_valid}, 32'd1);
      chk("reporting", {31'd0, reporting}, 32'd1);
      chk("word", {24'd0, dout}, {24'd0, w[idx]});
      if (pat == 0) dout_ready = 1'b1;
      else dout_ready = (k % 4 == 0) || (k % 4 == 3);
      start_harvest = hold ||
        (retrig && (k == 2 || (idx == 5 && dout_ready)));
      if (chg && k == 0) probe = 20'h12345;
      step();
      if (dout_ready) idx++;
      k++;
    end
    if (idx < 6) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d words want 6", idx);
    end
    if (!hold) start_harvest = 1'b0;
    chk("rep_end", {31'd0, reporting}, 32'd0);
    chk("valid_end", {31'd0, dout_valid}, 32'd0);
  endtask

  task automatic capture(input logic [19:0] p);
    probe = p;
    start_harvest = 1'b1;
    tcap = ts_m;
    step();
    start_harvest = 1'b0;
  endtask

  initial begin
    int n;
    arst = 1'b1;
    probe = '0;
    start_harvest = 1'b0;
    dout_ready = 1'b0;
    #7;
    chk("rst_rep", {31'd0, reporting}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    #1 arst = 1'b0;

    // Basic report captured with ts = 0x0010.
    tbl[0] = '{1'b1, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'h10};
    tbl[2] = '{1'b0, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'hDE};
    tbl[4] = '{1'b0, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'hBC};
    tbl[5] = '{1'b0, 1'b1, 20'hABCDE, 1'b1, 1'b1, 8'h0A};
    tbl[6] = '{1'b0, 1'b1, 20'hABCDE, 1'b0, 1'b0, 8'h00};

    n = 0;
    step();
    while (ts_m != 16'h0010 && n < 100) begin
      step();
      n++;
    end
    chk("ts_align", {16'd0, ts_m}, 32'h10);
    for (int i = 0; i < 7; i++) begin
      start_harvest = tbl[i].start;
      dout_ready = tbl[i].rdy;
      probe = tbl[i].p;
      step();
      chk("tbl_rep", {31'd0, reporting}, {31'd0, tbl[i].exp_rep});
      chk("tbl_valid", {31'd0, dout_valid}, {31'd0, tbl[i].exp_rep});
      if (tbl[i].chk_dout)
        chk("tbl_dout", {24'd0, dout}, {24'd0, tbl[i].exp_dout});
    end

    // Back-pressure, with probe changed right after capture.
    step();
    capture(20'hABCDE);
    drain(20'hABCDE, tcap, 1, 1'b1, 1'b0, 1'b0);

    // Busy retrigger: mid-report and on the final-accept edge.
    step();
    capture(20'h5A5A5);
    drain(20'h5A5A5, tcap, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_retrig", {31'd0, reporting}, 32'd0);
    end

    // Held start: back-to-back reports 7 cycles apart.
    probe = 20'hF0F0F;
    start_harvest = 1'b1;
    dout_ready = 1'b1;
    tcap = ts_m;
    step();
    drain(20'hF0F0F, tcap, 0, 1'b0, 1'b0, 1'b1);
    step();
    drain(20'hF0F0F, tcap + 16'd7, 0, 1'b0, 1'b0, 1'b1);
    start_harvest = 1'b0;
    step();
    chk("held_stop", {31'd0, reporting}, 32'd0);

    // Reset during timestamp words.
    capture(20'h13579);
    dout_ready = 1'b1;
    step();
    step();
    chk("pre_rst_dout", {24'd0, dout}, {24'd0, tcap[15:8]});
    arst = 1'b1;
    #1;
    chk("mid_rst_rep", {31'd0, reporting}, 32'd0);
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    #1 arst = 1'b0;
    capture(20'h2468A);
    drain(20'h2468A, 16'h0000, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
